instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage directly upstream of the control decoder. Holds the PC and issues
//  word reads to instruction memory over a req/ack handshake. Latches each returned
//  word into an instruction register and splits it into op/rs/rt/rd/imm; op drives
//  control.op. Honours hold/unhold stalls and branch/jump redirects.
// PARAMETERS
//  ADDR_W    32   PC / instruction-memory address width
//  RESET_PC  0    PC value loaded on reset (low 2 bits must be 0)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  imem_req     out  1       read request, held high until imem_ack
//  imem_addr    out  ADDR_W  word address of request (= pc), stable while req high
//  imem_ack     in   1       one-cycle pulse: imem_rdata valid this cycle
//  imem_rdata   in   32      instruction word
//  hold         in   1       stall from control: freeze current instruction
//  unhold       in   1       one-cycle pulse releasing a hold
//  redirect     in   1       one-cycle pulse: taken BEQ/JUMP/IRET
//  redirect_pc  in   ADDR_W  target of redirect
//  id_valid     out  1       op/rs/rt/rd/imm/id_pc hold a live instruction
//  id_ready     in   1       downstream accepts instruction this cycle
//  op           out  6       instr[31:26]
//  rs, rt, rd   out  5 each  instr[25:21], [20:16], [15:11]
//  imm          out  16      instr[15:0]
//  id_pc        out  ADDR_W  PC of the instruction on op..imm
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=FETCH, imem_req=0,
//   imem_addr=RESET_PC, id_valid=0, ir=0 (op..imm=0), id_pc=0, flush_pend=0.
//  First imem_req rises on the first clk edge after rst_n deasserts.
//  States:
//   FETCH: imem_req=1, imem_addr=pc. On imem_ack: if flush_pend, drop word, clear
//          flush_pend, stay FETCH (new req next cycle); else ir<=rdata,
//          id_pc<=pc, pc<=pc+4, -> VALID.
//   VALID: id_valid=1. hold=1 -> HOLD (hold has priority over id_ready).
//          id_ready=1 & hold=0 -> FETCH. Otherwise stay; outputs stable.
//   HOLD:  id_valid=1, ir frozen, no request. unhold=1 -> VALID.
//          hold and unhold both high: unhold wins.
//  Fetch latency: ack cycle +1 -> id_valid. Back-to-back throughput: 1 instr per
//   (memory latency + 2) cycles; no prefetch.
//  redirect (any state, highest priority):
//   pc<={redirect_pc[ADDR_W-1:2],2'b00}; id_valid drops next cycle; -> FETCH.
//   If in FETCH with imem_req high and no ack this cycle: req stays high on the old
//   address (no abort), flush_pend<=1; returned word discarded, then target fetched.
//   redirect and imem_ack same cycle: word discarded, no flush_pend set.
//   redirect while in HOLD clears the hold.
//  PC arithmetic: pc+4 modulo 2^ADDR_W (wrap to 0, no flag).
//  imem_addr never changes while imem_req=1 and imem_ack=0.
//  Reset mid-transaction: req drops immediately, a late ack after release is
//   ignored only if it arrives before FETCH re-issues; memory must abandon on reset.
// TESTING
//  1 Reset release, mem ack after 2 cycles returning 0x0022_1800 ->
//    req@cyc1 addr 0; id_valid@cyc4; op=0 rs=1 rt=2 rd=3 id_pc=0.
//  2 Sequential fetch, id_ready tied 1, 4 words -> addrs 0,4,8,C; id_pc matches each.
//  3 hold=1 during VALID for 5 cycles, unhold pulse -> no req issued, op stable,
//    fetch of next addr resumes one cycle after unhold.
//  4 redirect to 0x103 while req pending on 0x8 -> ack word for 0x8 discarded,
//    next req addr 0x100, id_valid never asserted for 0x8.
//  5 RESET_PC=0xFFFF_FFFC -> after one instr next req addr 0x0000_0000.
//  6 rst_n low mid-WAIT with req high -> req, id_valid 0 same cycle; refetch RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction-memory read bus between fetch stage and memory
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, imem req/ack, instruction register, stalls and redirects
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_if.master     imem,
  input  logic              hold,
  input  logic              unhold,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] id_pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic              flush_pend;
  logic              valid_q;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] id_pc_q;
  logic [ADDR_W-1:0] target;

  // Redirect targets are forced word-aligned; masking keeps every input bit in use.
  assign target = redirect_pc & ~(ADDR_W'(3));

  // Fetch FSM; a redirect overrides every state, and a request already on the
  // bus is never withdrawn, so its word is discarded via flush_pend instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      flush_pend <= 1'b0;
      valid_q    <= 1'b0;
      ir         <= '0;
      id_pc_q    <= '0;
    end else if (redirect) begin
      pc      <= target;
      valid_q <= 1'b0;
      state   <= S_FETCH;
      if (state == S_FETCH && req_q && !imem.imem_ack) begin
        flush_pend <= 1'b1;
      end else if (state == S_FETCH && req_q && imem.imem_ack) begin
        req_q      <= 1'b0;
        flush_pend <= 1'b0;
      end else begin
        req_q      <= 1'b1;
        addr_q     <= target;
        flush_pend <= 1'b0;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= pc;
          end else if (imem.imem_ack) begin
            req_q <= 1'b0;
            if (flush_pend) begin
              flush_pend <= 1'b0;
            end else begin
              ir      <= imem.imem_rdata;
              id_pc_q <= pc;
              pc      <= pc + ADDR_W'(4);
              valid_q <= 1'b1;
              state   <= S_VALID;
            end
          end
        end
        S_VALID: begin
          if (hold) begin
            state <= S_HOLD;
          end else if (id_ready) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            addr_q  <= pc;
            state   <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (unhold) begin
            state <= S_VALID;
          end
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign id_valid       = valid_q;
  assign id_pc          = id_pc_q;
  assign op             = ir[31:26];
  assign rs             = ir[25:21];
  assign rt             = ir[20:16];
  assign rd             = ir[15:11];
  assign imm            = ir[15:0];

endmodule
